// File: rtl/pci_initiator_if.sv
// Request, status and PCI control signals between the burst initiator and its environment.
// The multiplexed AD bus is a separate inout port on the initiator.
interface pci_initiator_if;
  logic        start;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [3:0]  burst_len;
  logic [31:0] wr_data;
  logic        wr_data_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe;
  logic        trdy_n;

  modport master (
    input  start, cmd, addr, burst_len, wr_data, trdy_n,
    output wr_data_req, rd_data, rd_valid, busy, done, err, frame_n, irdy_n, cbe
  );

  modport slave (
    output start, cmd, addr, burst_len, wr_data, trdy_n,
    input  wr_data_req, rd_data, rd_valid, busy, done, err, frame_n, irdy_n, cbe
  );
endinterface

// File: rtl/pci_initiator.sv
// PCI-style burst initiator: one address phase plus up to MAX_BURST data phases,
// paced by TRDY#, with a wait-cycle watchdog that aborts stalled transactions.
module pci_initiator #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pci_initiator_if.master bus,
  inout  wire [31:0]      ad
);

  localparam int unsigned DW     = 32;
  localparam int unsigned CW     = 4;
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CMD_MEM_WRITE = 4'b0111;
  localparam logic [CW-1:0] CBE_IDLE      = 4'b1111;
  localparam logic [CW-1:0] CBE_DATA      = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TAR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cmd_q, cmd_d;
  logic [DW-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              frame_n_q, frame_n_d;
  logic              irdy_n_q, irdy_n_d;
  logic [CW-1:0]     cbe_q, cbe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              is_write;
  logic              in_data;
  logic              complete;
  logic              timeout_hit;
  logic              accept;
  logic [CNT_W-1:0]  len_clamped;

  assign is_write    = (cmd_q == CMD_MEM_WRITE);
  assign in_data     = (state_q == DATA);
  assign complete    = in_data && !bus.trdy_n;
  assign timeout_hit = in_data && bus.trdy_n && (wait_q == WAIT_W'(TIMEOUT - 1));
  assign accept      = (state_q == IDLE) && bus.start;

  // Zero-length requests become one phase; oversize requests are clamped.
  always_comb begin
    if (bus.burst_len == '0) begin
      len_clamped = CNT_W'(1);
    end else if (32'(bus.burst_len) > MAX_BURST) begin
      len_clamped = CNT_W'(MAX_BURST);
    end else begin
      len_clamped = CNT_W'(bus.burst_len);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      frame_n_q   <= 1'b1;
      irdy_n_q    <= 1'b1;
      cbe_q       <= CBE_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      frame_n_q   <= frame_n_d;
      irdy_n_q    <= irdy_n_d;
      cbe_q       <= cbe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Next-state: a completion always beats a simultaneous watchdog expiry.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = ADDR;
          cmd_d       = bus.cmd;
          addr_d      = bus.addr;
          remaining_d = len_clamped;
          wait_d      = '0;
        end
      end
      ADDR: begin
        state_d = DATA;
      end
      DATA: begin
        if (complete) begin
          remaining_d = remaining_q - CNT_W'(1);
          wait_d      = '0;
          if (remaining_q == CNT_W'(1)) begin
            state_d = TAR;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (timeout_hit) begin
            state_d = TAR;
          end
        end
      end
      TAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it after the edge.
  always_comb begin
    frame_n_d  = 1'b1;
    irdy_n_d   = 1'b1;
    cbe_d      = CBE_IDLE;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    rd_valid_d = complete && !is_write;
    rd_data_d  = rd_valid_d ? ad : rd_data_q;
    if (accept) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
    case (state_d)
      ADDR: begin
        frame_n_d = 1'b0;
        cbe_d     = cmd_d;
        busy_d    = 1'b1;
      end
      DATA: begin
        frame_n_d = (remaining_d == CNT_W'(1));
        irdy_n_d  = 1'b0;
        cbe_d     = CBE_DATA;
        busy_d    = 1'b1;
      end
      TAR: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // AD is driven only for the address phase and write data phases.
  assign ad = (state_q == ADDR)          ? addr_q      :
              (in_data && is_write)      ? bus.wr_data :
                                           {DW{1'bz}};

  assign bus.wr_data_req = in_data && is_write && !bus.trdy_n;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.frame_n     = frame_n_q;
  assign bus.irdy_n      = irdy_n_q;
  assign bus.cbe         = cbe_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Self-checking bench for pci_initiator: a transaction-level model expands each request
// into per-cycle stimulus and expected bus/status values, compared against the DUT.
module tb_pci_initiator;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pci_initiator_if bus ();
  wire  [31:0] ad;
  logic        tb_en;
  logic [31:0] tb_val;
  assign ad = tb_en ? tb_val : {32{1'bz}};

  pci_initiator #(.MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .ad   (ad)
  );

  typedef struct packed {
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  cbe;
    logic [31:0] ad;
    logic        wr_req;
    logic        busy;
    logic        done;
    logic        err;
    logic        rd_valid;
    logic [31:0] rd_data;
  } obs_t;

  typedef struct packed {
    logic        rst_n;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  len;
    logic        trdy_n;
    logic [31:0] wr_data;
    logic        en;
    logic [31:0] val;
    obs_t        exp;
  } step_t;

  step_t       steps[$];
  obs_t        obs_q[$];
  int unsigned waits[16];
  logic [31:0] words[16];
  logic        m_err;
  logic [31:0] m_rd;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  function automatic logic nz(input bit noise);
    return noise && ($urandom_range(0, 3) == 0);
  endfunction

  function automatic obs_t mk_obs(input logic fr, input logic ir, input logic [3:0] cb,
                                  input logic [31:0] a, input logic wq, input logic bz,
                                  input logic dn, input logic er, input logic rv);
    obs_t o;
    o.frame_n = fr; o.irdy_n = ir; o.cbe = cb; o.ad = a; o.wr_req = wq;
    o.busy = bz; o.done = dn; o.err = er; o.rd_valid = rv; o.rd_data = m_rd;
    return o;
  endfunction

  task automatic add_step(input logic rs, input logic st, input logic trdy, input logic [31:0] wd,
                          input logic [3:0] cmd, input logic [31:0] addr, input logic [3:0] len,
                          input logic en, input logic [31:0] val, input obs_t e);
    step_t s;
    s.rst_n = rs; s.start = st; s.cmd = cmd; s.addr = addr; s.len = len; s.trdy_n = trdy;
    s.wr_data = wd; s.en = en; s.val = val; s.exp = e;
    steps.push_back(s);
  endtask

  task automatic add_idle();
    logic [31:0] j;
    j = $urandom;
    add_step(1'b1, 1'b0, 1'($urandom), $urandom, r4(), $urandom, r4(), 1'b1, j,
             mk_obs(1'b1, 1'b1, 4'hF, j, 1'b0, 1'b0, 1'b0, m_err, 1'b0));
  endtask

  task automatic add_rst_step();
    logic [31:0] j;
    m_err = 1'b0;
    m_rd  = 32'h0;
    j = $urandom;
    add_step(1'b0, 1'b1, 1'b0, $urandom, 4'b0111, $urandom, r4(), 1'b1, j,
             mk_obs(1'b1, 1'b1, 4'hF, j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Expand one request into cycles: request, address, data phases with waits, turnaround.
  task automatic model_txn(input logic [3:0] cmd, input logic [31:0] addr, input logic [3:0] len,
                           input bit noise);
    bit          wr, prc, to;
    int unsigned n, wc;
    logic        fr;
    logic [31:0] j, wd;
    wr = (cmd == 4'b0111);
    n  = (len == 4'd0) ? 1 : ((32'(len) > MAX_BURST) ? MAX_BURST : 32'(len));
    j = $urandom;
    add_step(1'b1, 1'b1, 1'($urandom), $urandom, cmd, addr, len, 1'b1, j,
             mk_obs(1'b1, 1'b1, 4'hF, j, 1'b0, 1'b0, 1'b0, m_err, 1'b0));
    m_err = 1'b0;
    add_step(1'b1, nz(noise), 1'b1, $urandom, r4(), $urandom, r4(), 1'b0, 32'h0,
             mk_obs(1'b0, 1'b1, cmd, addr, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    wc = 0; prc = 1'b0; to = 1'b0;
    for (int unsigned p = 0; p < n && !to; p++) begin
      fr = ((n - p) == 1);
      for (int unsigned k = 0; k < waits[p]; k++) begin
        j  = $urandom;
        wd = wr ? words[p] : $urandom;
        add_step(1'b1, nz(noise), 1'b1, wd, r4(), $urandom, r4(), !wr, j,
                 mk_obs(fr, 1'b0, 4'h0, wr ? words[p] : j, 1'b0, 1'b1, 1'b0, 1'b0, prc));
        prc = 1'b0;
        wc++;
        if (wc == TIMEOUT) begin
          to = 1'b1;
          break;
        end
      end
      if (!to) begin
        wd = wr ? words[p] : $urandom;
        add_step(1'b1, nz(noise), 1'b0, wd, r4(), $urandom, r4(), !wr, words[p],
                 mk_obs(fr, 1'b0, 4'h0, words[p], wr, 1'b1, 1'b0, 1'b0, prc));
        if (!wr) m_rd = words[p];
        prc = !wr;
        wc = 0;
      end
    end
    j = $urandom;
    add_step(1'b1, nz(noise), 1'($urandom), $urandom, r4(), $urandom, r4(), 1'b1, j,
             mk_obs(1'b1, 1'b1, 4'hF, j, 1'b0, 1'b1, 1'b1, to, prc));
    m_err = to;
  endtask

  task automatic run_steps();
    obs_t o;
    obs_q.delete();
    foreach (steps[i]) begin
      @(posedge clk);
      #1;
      rst_n         = steps[i].rst_n;
      bus.start     = steps[i].start;
      bus.cmd       = steps[i].cmd;
      bus.addr      = steps[i].addr;
      bus.burst_len = steps[i].len;
      bus.trdy_n    = steps[i].trdy_n;
      bus.wr_data   = steps[i].wr_data;
      tb_en         = steps[i].en;
      tb_val        = steps[i].val;
      @(negedge clk);
      o.frame_n = bus.frame_n; o.irdy_n = bus.irdy_n; o.cbe = bus.cbe; o.ad = ad;
      o.wr_req = bus.wr_data_req; o.busy = bus.busy; o.done = bus.done; o.err = bus.err;
      o.rd_valid = bus.rd_valid; o.rd_data = bus.rd_data;
      obs_q.push_back(o);
    end
  endtask

  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 16; i++) begin
      words[i] = $urandom;
      waits[i] = 0;
    end
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
  endtask

  task automatic test_reset();
    steps.delete();
    add_rst_step();
    add_rst_step();
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL reset cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_write_burst();
    steps.delete();
    set_words(32'haa, 32'hbb, 32'hcc, 32'hdd);
    model_txn(4'b0111, 32'h100, 4'd4, 1'b0);
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL write_burst cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_read_waits();
    steps.delete();
    set_words(32'h11, 32'h22, 32'h33, $urandom);
    waits[1] = 2;
    model_txn(4'b0110, 32'h200, 4'd3, 1'b0);
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL read_waits cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_single_phase();
    steps.delete();
    set_words($urandom, $urandom, $urandom, $urandom);
    model_txn(4'b0111, $urandom, 4'd0, 1'b0);
    model_txn(4'b0011, $urandom, 4'd0, 1'b0);
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL single_phase cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    steps.delete();
    set_words($urandom, $urandom, $urandom, $urandom);
    waits[0] = TIMEOUT;
    model_txn(4'b0111, $urandom, 4'd2, 1'b0);
    add_idle();
    set_words($urandom, $urandom, $urandom, $urandom);
    waits[0] = TIMEOUT - 1;
    waits[1] = TIMEOUT - 1;
    model_txn(4'b0111, $urandom, 4'd2, 1'b0);
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL timeout cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_clamp();
    steps.delete();
    set_words($urandom, $urandom, $urandom, $urandom);
    model_txn(4'b0110, $urandom, 4'd12, 1'b0);
    model_txn(4'b0111, $urandom, 4'd15, 1'b0);
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL clamp cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_burst();
    steps.delete();
    set_words($urandom, $urandom, $urandom, $urandom);
    model_txn(4'b0111, $urandom, 4'd8, 1'b0);
    while (steps.size() > 5) void'(steps.pop_back());
    steps[3].start = 1'b1;
    add_rst_step();
    add_idle();
    add_idle();
    model_txn(4'b0111, $urandom, 4'd1, 1'b0);
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL reset_mid_burst cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [3:0] cmd;
    steps.delete();
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) begin
        words[i] = $urandom;
        waits[i] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      end
      if ($urandom_range(0, 7) == 0) waits[$urandom_range(0, 3)] = TIMEOUT;
      case ($urandom_range(0, 3))
        0:       cmd = 4'b0110;
        1, 2:    cmd = 4'b0111;
        default: cmd = r4();
      endcase
      model_txn(cmd, $urandom, r4(), 1'b1);
      if ($urandom_range(0, 2) == 0) add_idle();
    end
    add_idle();
    run_steps();
    foreach (steps[i]) begin
      checks++;
      if (obs_q[i] !== steps[i].exp)
        $display("FAIL random cycle %0d: got %h, want %h", i, obs_q[i], steps[i].exp);
      else passes++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cmd = 4'h0; bus.addr = 32'h0; bus.burst_len = 4'h0;
    bus.wr_data = 32'h0; bus.trdy_n = 1'b1;
    tb_en = 1'b1; tb_val = 32'h0;
    m_err = 1'b0; m_rd = 32'h0;
    test_reset();
    test_write_burst();
    test_read_waits();
    test_single_phase();
    test_timeout();
    test_clamp();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
